press_decoder: RTL and testbench

- Sits directly downstream of the pushbutton debouncer. Consumes its single-cycle, rising-edge press pulse.
- Groups presses that arrive within a programmable gap window into one multi-click event: single, double, or up to MAX_PRESSES clicks.
- Emits a one-cycle event strobe with the click count to the mode/control logic.
- Lets one physical button select several functions.

---
 rtl/press_decoder.sv | 98 +++++++++
 tb/tb_press_decoder.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/press_decoder.sv
// Multi-click decoder: groups debounced press pulses separated by at most WINDOW cycles
// and reports the group size as a one-cycle event strobe.
module press_decoder #(
   parameter int unsigned WINDOW      = 25000000,
   parameter int unsigned TMR_W       = 25,
   parameter int unsigned MAX_PRESSES = 3,
   parameter int unsigned CNT_W       = 2
) (
   input  logic             clk,
   input  logic             clear,
   input  logic             pb_pulse,
   output logic             event_valid,
   output logic [CNT_W-1:0] event_count,
   output logic             busy
);

   typedef enum logic [1:0] {StIdle, StCollect, StEmit} state_e;

   // Timer reaches TmrLast on the edge WINDOW-1 after the last press, so expiry is
   // decided on the WINDOW-th edge.
   localparam logic [TMR_W-1:0] TmrLast = TMR_W'(WINDOW - 1);
   localparam logic [CNT_W-1:0] CntLast = CNT_W'(MAX_PRESSES - 1);
   localparam logic [CNT_W-1:0] CntMax  = CNT_W'(MAX_PRESSES);
   localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [TMR_W-1:0] tmr_q, tmr_d;
   logic             event_valid_d, busy_d;
   logic [CNT_W-1:0] event_count_d;

   always_ff @(posedge clk or posedge clear) begin
      if (clear) begin
         state_q     <= StIdle;
         cnt_q       <= '0;
         tmr_q       <= '0;
         event_valid <= 1'b0;
         event_count <= '0;
         busy        <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         tmr_q       <= tmr_d;
         event_valid <= event_valid_d;
         event_count <= event_count_d;
         busy        <= busy_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      tmr_d   = tmr_q;
      unique case (state_q)
         StIdle, StEmit: begin
            // A press in the strobe cycle opens the next group rather than being dropped.
            if (pb_pulse) begin
               state_d = StCollect;
               cnt_d   = CntOne;
               tmr_d   = '0;
            end else begin
               state_d = StIdle;
               cnt_d   = '0;
               tmr_d   = '0;
            end
         end
         StCollect: begin
            if (pb_pulse && (cnt_q == CntLast)) begin
               state_d = StEmit;
               cnt_d   = CntMax;
            end else if (pb_pulse) begin
               cnt_d = cnt_q + CntOne;
               tmr_d = '0;
            end else if (tmr_q == TmrLast) begin
               state_d = StEmit;
            end else begin
               tmr_d = tmr_q + 1'b1;
            end
         end
         default: begin
            state_d = StIdle;
            cnt_d   = '0;
            tmr_d   = '0;
         end
      endcase
   end

   always_comb begin
      event_valid_d = (state_d == StEmit);
      busy_d        = (state_d == StCollect);
      event_count_d = event_count;
      // StEmit is only entered from StCollect; a press on that edge means the max was hit.
      if (state_d == StEmit) begin
         event_count_d = pb_pulse ? CntMax : cnt_q;
      end
   end

endmodule

// File: tb/tb_press_decoder.sv
// Bench for press_decoder: directed click scenarios plus randomized pulses and async clears,
// all compared against a deadline-based model of press groups.
module tb_press_decoder;

   localparam int unsigned WINDOW      = 8;
   localparam int unsigned TMR_W       = 4;
   localparam int unsigned MAX_PRESSES = 3;
   localparam int unsigned CNT_W       = 2;

   logic             clk;
   logic             clear;
   logic             pb_pulse;
   logic             event_valid;
   logic [CNT_W-1:0] event_count;
   logic             busy;

   int checks   = 0;
   int failures = 0;

   // Model: an open group remembers its size and the edge of its last press.
   int         edge_n;
   bit         m_open;
   int         m_cnt;
   int         m_last;
   bit         m_valid;
   logic [1:0] m_count;

   press_decoder #(
      .WINDOW     (WINDOW),
      .TMR_W      (TMR_W),
      .MAX_PRESSES(MAX_PRESSES),
      .CNT_W      (CNT_W)
   ) dut (
      .clk        (clk),
      .clear      (clear),
      .pb_pulse   (pb_pulse),
      .event_valid(event_valid),
      .event_count(event_count),
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic model_reset();
      m_open  = 1'b0;
      m_cnt   = 0;
      m_last  = 0;
      m_valid = 1'b0;
      m_count = 2'd0;
   endtask

   task automatic model_edge(input logic p);
      bit v;
      v = 1'b0;
      if (!m_open) begin
         if (p) begin
            m_open = 1'b1;
            m_cnt  = 1;
            m_last = edge_n;
         end
      end else if (p) begin
         if (m_cnt + 1 == MAX_PRESSES) begin
            v       = 1'b1;
            m_count = 2'(MAX_PRESSES);
            m_open  = 1'b0;
         end else begin
            m_cnt  = m_cnt + 1;
            m_last = edge_n;
         end
      end else if (edge_n - m_last >= WINDOW) begin
         v       = 1'b1;
         m_count = 2'(m_cnt);
         m_open  = 1'b0;
      end
      m_valid = v;
   endtask

   // Drive one edge's input, advance the model, sample 1 ns after the edge.
   task automatic step(input logic p);
      @(negedge clk);
      pb_pulse = p;
      @(posedge clk);
      edge_n = edge_n + 1;
      model_edge(p);
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      pb_pulse = 1'b0;
      clear    = 1'b1;
      #2;
      clear = 1'b0;
      model_reset();
      edge_n = 0;
   endtask

   task automatic test_reset();
      pb_pulse = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({event_valid, event_count, busy} !== 4'b0000) begin
         failures++;
         $display("FAIL reset_hold got v=%b c=%0d b=%b exp all zero", event_valid, event_count, busy);
      end
      do_reset();
      step(1'b0);
      checks++;
      if ({event_valid, event_count, busy} !== 4'b0000) begin
         failures++;
         $display("FAIL reset_release got v=%b c=%0d b=%b exp all zero",
                  event_valid, event_count, busy);
      end
   endtask

   task automatic test_groups();
      logic [63:0] pat [6];
      int          ev_e[6];
      int          ev_c[6];
      pat[0] = 64'd1 << 10;                                   ev_e[0] = 18; ev_c[0] = 1;
      pat[1] = (64'd1 << 10) | (64'd1 << 14);                 ev_e[1] = 22; ev_c[1] = 2;
      pat[2] = (64'd1 << 10) | (64'd1 << 12) | (64'd1 << 14); ev_e[2] = 14; ev_c[2] = 3;
      pat[3] = (64'd1 << 10) | (64'd1 << 18);                 ev_e[3] = 26; ev_c[3] = 2;
      pat[4] = (64'd1 << 10) | (64'd1 << 19);                 ev_e[4] = 18; ev_c[4] = 1;
      pat[5] = (64'd1 << 10) | (64'd1 << 19);                 ev_e[5] = 27; ev_c[5] = 1;
      for (int i = 0; i < 6; i++) begin
         do_reset();
         for (int e = 1; e <= 40; e++) begin
            step(pat[i][e]);
            checks++;
            if ({event_valid, event_count, busy} !== {m_valid, m_count, m_open}) begin
               failures++;
               $display("FAIL groups[%0d] edge=%0d got v=%b c=%0d b=%b exp v=%b c=%0d b=%b", i, e,
                        event_valid, event_count, busy, m_valid, m_count, m_open);
            end
            if (e == ev_e[i]) begin
               checks++;
               if (event_valid !== 1'b1 || event_count !== 2'(ev_c[i])) begin
                  failures++;
                  $display("FAIL groups_event[%0d] edge=%0d got v=%b c=%0d exp v=1 c=%0d", i, e,
                           event_valid, event_count, ev_c[i]);
               end
            end
         end
      end
   endtask

   task automatic test_back_to_back();
      do_reset();
      for (int e = 1; e <= 30; e++) begin
         step((e >= 10 && e <= 14) ? 1'b1 : 1'b0);
         checks++;
         if ({event_valid, event_count, busy} !== {m_valid, m_count, m_open}) begin
            failures++;
            $display("FAIL held edge=%0d got v=%b c=%0d b=%b exp v=%b c=%0d b=%b", e,
                     event_valid, event_count, busy, m_valid, m_count, m_open);
         end
         if (e == 12 || e == 22) begin
            checks++;
            if (event_valid !== 1'b1 || event_count !== ((e == 12) ? 2'd3 : 2'd2)) begin
               failures++;
               $display("FAIL held_event edge=%0d got v=%b c=%0d exp v=1 c=%0d", e,
                        event_valid, event_count, (e == 12) ? 3 : 2);
            end
         end
         if (e > 12 && e < 22) begin
            checks++;
            if (event_count !== 2'd3 || event_valid !== 1'b0) begin
               failures++;
               $display("FAIL held_hold edge=%0d got v=%b c=%0d exp v=0 c=3", e,
                        event_valid, event_count);
            end
         end
      end
   endtask

   task automatic test_async_clear();
      do_reset();
      for (int e = 1; e <= 45; e++) begin
         step((e == 10 || e == 12 || e == 30) ? 1'b1 : 1'b0);
         checks++;
         if ({event_valid, event_count, busy} !== {m_valid, m_count, m_open}) begin
            failures++;
            $display("FAIL clear edge=%0d got v=%b c=%0d b=%b exp v=%b c=%0d b=%b", e,
                     event_valid, event_count, busy, m_valid, m_count, m_open);
         end
         if (e == 14) begin
            #2;
            clear = 1'b1;
            #1;
            checks++;
            if ({event_valid, event_count, busy} !== 4'b0000) begin
               failures++;
               $display("FAIL clear_async got v=%b c=%0d b=%b exp all zero",
                        event_valid, event_count, busy);
            end
            clear = 1'b0;
            model_reset();
         end
         if (e == 38) begin
            checks++;
            if (event_valid !== 1'b1 || event_count !== 2'd1) begin
               failures++;
               $display("FAIL clear_after edge=38 got v=%b c=%0d exp v=1 c=1",
                        event_valid, event_count);
            end
         end
      end
   endtask

   task automatic test_random();
      int dens;
      do_reset();
      dens = 1;
      for (int e = 1; e <= 4000; e++) begin
         if (e % 200 == 0) dens = $urandom_range(0, 5);
         step(($urandom_range(0, 15) < dens) ? 1'b1 : 1'b0);
         checks++;
         if ({event_valid, event_count, busy} !== {m_valid, m_count, m_open}) begin
            failures++;
            $display("FAIL random edge=%0d got v=%b c=%0d b=%b exp v=%b c=%0d b=%b", e,
                     event_valid, event_count, busy, m_valid, m_count, m_open);
         end
         if ($urandom_range(0, 399) == 0) begin
            #1;
            clear = 1'b1;
            #1;
            checks++;
            if ({event_valid, event_count, busy} !== 4'b0000) begin
               failures++;
               $display("FAIL random_clear edge=%0d got v=%b c=%0d b=%b exp all zero", e,
                        event_valid, event_count, busy);
            end
            clear = 1'b0;
            model_reset();
         end
      end
   endtask

   initial begin
      clear    = 1'b1;
      pb_pulse = 1'b0;
      edge_n   = 0;
      model_reset();
      test_reset();
      test_groups();
      test_back_to_back();
      test_async_clear();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
